// File: rtl/cmd_register_bank.sv
// rtl/cmd_register_bank.sv - GPIO command/status register bank driving the Tx/Rx datapath
module cmd_register_bank #(
  parameter int NB_COM  = 8,
  parameter int NB_INST = 32,
  parameter int NB_BER  = 64,
  parameter int N_CH    = 2,
  parameter int NB_ADDR = 15,
  parameter int MEM_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NB_INST-1:0]     i_cmd_from_micro,
  output logic [NB_INST-1:0]     o_data_to_micro,
  input  logic                   i_mem_full,
  input  logic [NB_INST-1:0]     i_data_log_from_mem,
  input  logic [N_CH*NB_BER-1:0] i_ber_samp,
  input  logic [N_CH*NB_BER-1:0] i_ber_error,
  output logic                   o_reset,
  output logic                   o_enbTx,
  output logic                   o_enbRx,
  output logic [1:0]             o_phase_sel,
  output logic                   o_run_log,
  output logic                   o_read_log,
  output logic [NB_ADDR-1:0]     o_addr_log_to_mem
);
  localparam int EN_BIT = 23;
  localparam logic [NB_COM-1:0] OP_RESET = NB_COM'(8'h01);
  localparam logic [NB_COM-1:0] OP_EN_TX = NB_COM'(8'h02);
  localparam logic [NB_COM-1:0] OP_EN_RX = NB_COM'(8'h03);
  localparam logic [NB_COM-1:0] OP_PHSEL = NB_COM'(8'h04);
  localparam logic [NB_COM-1:0] OP_RUN   = NB_COM'(8'h05);
  localparam logic [NB_COM-1:0] OP_RD    = NB_COM'(8'h06);
  localparam logic [NB_COM-1:0] OP_NEXT  = NB_COM'(8'h07);
  localparam logic [NB_COM-1:0] OP_FULL  = NB_COM'(8'h08);
  localparam logic [NB_COM-1:0] OP_SNAP  = NB_COM'(8'h09);
  localparam logic [NB_COM-1:0] OP_BER   = NB_COM'(8'h0A);
  localparam logic [NB_COM-1:0] OP_STAT  = NB_COM'(8'h0B);
  localparam logic [7:0]        NCH8     = 8'(N_CH);
  localparam logic [1:0]        LAT_LAST = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [NB_INST-1:0]     cmd_s1_q, cmd_s2_q;
  logic                   en_s3_q;
  logic [NB_INST-1:0]     cmd_q, cmd_d, pend_word_q, pend_word_d, data_q, data_d;
  logic                   pend_vld_q, pend_vld_d, ovf_q, ovf_d;
  logic [1:0]             lat_q, lat_d, phase_q, phase_d;
  logic                   reset_q, reset_d, enbtx_q, enbtx_d, enbrx_q, enbrx_d;
  logic                   run_q, run_d, read_q, read_d;
  logic [NB_ADDR-1:0]     addr_q, addr_d;
  logic [N_CH*NB_BER-1:0] snap_s_q, snap_s_d, snap_e_q, snap_e_d;
  logic                   cmd_event, ch_ok;
  logic [NB_COM-1:0]      op;
  logic [NB_BER-1:0]      ber_word;

  // Data bits ride the same two-flop pipeline as the strobe so they are stable at capture.
  assign cmd_event = cmd_s2_q[EN_BIT] & ~en_s3_q;
  assign op        = cmd_q[NB_INST-1 -: NB_COM];

  always_comb begin
    ber_word = '0;
    ch_ok    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (cmd_q[3:0] == 4'(k)) begin
        ch_ok    = 1'b1;
        ber_word = cmd_q[4] ? snap_e_q[k*NB_BER +: NB_BER] : snap_s_q[k*NB_BER +: NB_BER];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    pend_vld_d  = pend_vld_q;
    pend_word_d = pend_word_q;
    ovf_d       = ovf_q;
    lat_d       = lat_q;
    data_d      = data_q;
    reset_d     = reset_q;
    enbtx_d     = enbtx_q;
    enbrx_d     = enbrx_q;
    phase_d     = phase_q;
    run_d       = 1'b0;
    read_d      = read_q;
    addr_d      = addr_q;
    snap_s_d    = snap_s_q;
    snap_e_d    = snap_e_q;
    unique case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          cmd_d      = pend_word_q;
          pend_vld_d = 1'b0;
          state_d    = EXEC;
        end else if (cmd_event) begin
          cmd_d   = cmd_s2_q;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        data_d  = cmd_q;
        case (op)
          OP_RESET: reset_d = cmd_q[0];
          OP_EN_TX: enbtx_d = cmd_q[0];
          OP_EN_RX: enbrx_d = cmd_q[0];
          OP_PHSEL: phase_d = cmd_q[1:0];
          OP_RUN: begin
            read_d = 1'b0;
            run_d  = 1'b1;
          end
          OP_RD, OP_NEXT: begin
            if (i_mem_full) begin
              if (op == OP_RD) begin
                addr_d = cmd_q[NB_ADDR-1:0];
                read_d = 1'b1;
              end else begin
                addr_d = addr_q + 1'b1;
              end
              lat_d   = '0;
              data_d  = data_q;
              state_d = MEM_WAIT;
            end else begin
              data_d = {{(NB_INST-1){1'b1}}, 1'b0};
            end
          end
          OP_FULL: data_d = NB_INST'(i_mem_full);
          OP_SNAP: begin
            snap_s_d = i_ber_samp;
            snap_e_d = i_ber_error;
            data_d   = NB_INST'(1);
          end
          OP_BER: begin
            if (!ch_ok) data_d = {{(NB_INST-2){1'b1}}, 2'b01};
            else        data_d = cmd_q[5] ? ber_word[NB_BER-1 -: NB_INST] : ber_word[NB_INST-1:0];
          end
          OP_STAT: begin
            data_d = {16'h0, ovf_q, 7'h0, NCH8};
            ovf_d  = 1'b0;
          end
          default: data_d = {8'hEE, {(NB_INST-8-NB_COM){1'b0}}, op};
        endcase
      end
      MEM_WAIT: begin
        if (lat_q == LAT_LAST) begin
          data_d  = i_data_log_from_mem;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Evaluated last so an overflow in the same cycle as a STATUS read stays sticky.
    if (cmd_event) begin
      if (state_q == IDLE) begin
        if (pend_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_word_d = cmd_s2_q;
        end
      end else if (pend_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_vld_d  = 1'b1;
        pend_word_d = cmd_s2_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_s1_q    <= '0;
      cmd_s2_q    <= '0;
      en_s3_q     <= 1'b0;
      state_q     <= IDLE;
      cmd_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_word_q <= '0;
      ovf_q       <= 1'b0;
      lat_q       <= '0;
      data_q      <= '0;
      reset_q     <= 1'b0;
      enbtx_q     <= 1'b0;
      enbrx_q     <= 1'b0;
      phase_q     <= '0;
      run_q       <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      snap_s_q    <= '0;
      snap_e_q    <= '0;
    end else begin
      cmd_s1_q    <= i_cmd_from_micro;
      cmd_s2_q    <= cmd_s1_q;
      en_s3_q     <= cmd_s2_q[EN_BIT];
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pend_vld_q  <= pend_vld_d;
      pend_word_q <= pend_word_d;
      ovf_q       <= ovf_d;
      lat_q       <= lat_d;
      data_q      <= data_d;
      reset_q     <= reset_d;
      enbtx_q     <= enbtx_d;
      enbrx_q     <= enbrx_d;
      phase_q     <= phase_d;
      run_q       <= run_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      snap_s_q    <= snap_s_d;
      snap_e_q    <= snap_e_d;
    end
  end

  assign o_data_to_micro   = data_q;
  assign o_reset           = reset_q;
  assign o_enbTx           = enbtx_q;
  assign o_enbRx           = enbrx_q;
  assign o_phase_sel       = phase_q;
  assign o_run_log         = run_q;
  assign o_read_log        = read_q;
  assign o_addr_log_to_mem = addr_q;
endmodule

// File: tb/tb_cmd_register_bank.sv
// tb/tb_cmd_register_bank.sv - scoreboard bench for cmd_register_bank
module tb_cmd_register_bank;
  localparam int N_CH = 2;
  localparam int LAT  = 4;
  localparam logic [31:0] EN = 32'h0080_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       cmd = '0;
  logic [31:0]       rsp;
  logic              mem_full = 1'b0;
  logic [31:0]       mem_data;
  logic [N_CH*64-1:0] ber_s, ber_e;
  logic              o_reset, o_enbTx, o_enbRx, o_run_log, o_read_log;
  logic [1:0]        o_phase_sel;
  logic [14:0]       o_addr;
  logic [20:0]       dut_ctrl;

  logic [63:0] live_s [N_CH];
  logic [63:0] live_e [N_CH];
  logic [31:0] mpipe [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int run_at = -10;
  int t_issue = 0;

  // Reference model state
  bit          m_rst, m_tx, m_rx, m_rl, m_ovf;
  logic [1:0]  m_ph;
  int          m_addr;
  logic [63:0] snap_s [N_CH];
  logic [63:0] snap_e [N_CH];

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [20:0] ctrl;
  } exp_t;
  exp_t sb[$];

  cmd_register_bank #(.N_CH(N_CH), .MEM_LAT(LAT)) dut (
    .clock              (clock),
    .reset              (reset),
    .i_cmd_from_micro   (cmd),
    .o_data_to_micro    (rsp),
    .i_mem_full         (mem_full),
    .i_data_log_from_mem(mem_data),
    .i_ber_samp         (ber_s),
    .i_ber_error        (ber_e),
    .o_reset            (o_reset),
    .o_enbTx            (o_enbTx),
    .o_enbRx            (o_enbRx),
    .o_phase_sel        (o_phase_sel),
    .o_run_log          (o_run_log),
    .o_read_log         (o_read_log),
    .o_addr_log_to_mem  (o_addr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [14:0] a);
    return 32'hA5A5_0001 + {17'd0, a};
  endfunction

  // Log memory with LAT cycles of read latency
  always @(posedge clock) begin
    mpipe[0] <= memf(o_addr);
    mpipe[1] <= mpipe[0];
    mpipe[2] <= mpipe[1];
  end
  assign mem_data = mpipe[LAT-2];

  always_comb begin
    ber_s = '0;
    ber_e = '0;
    for (int k = 0; k < N_CH; k++) begin
      ber_s[k*64 +: 64] = live_s[k];
      ber_e[k*64 +: 64] = live_e[k];
    end
  end

  assign dut_ctrl = {o_reset, o_enbTx, o_enbRx, o_phase_sel, o_read_log, o_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares the response whose due cycle has arrived
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      if (sb[0].due == cyc) begin
        chk("resp_data", rsp, sb[0].data);
        chk("resp_ctrl", 32'(dut_ctrl), 32'(sb[0].ctrl));
        sb.delete(0);
      end else if (sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL resp_missed: due %0d now %0d", sb[0].due, cyc);
        sb.delete(0);
      end
    end
    if (cyc == run_at)     chk("run_pulse_hi", 32'(o_run_log), 32'd1);
    if (cyc == run_at + 1) chk("run_pulse_lo", 32'(o_run_log), 32'd0);
  end

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [22:0] d);
    return {op, 1'b0, d};
  endfunction

  task automatic model_reset();
    m_rst = 0; m_tx = 0; m_rx = 0; m_rl = 0; m_ovf = 0; m_ph = 0; m_addr = 0;
    for (int k = 0; k < N_CH; k++) begin
      snap_s[k] = '0;
      snap_e[k] = '0;
    end
  endtask

  task automatic model_push(input logic [31:0] w, input int extra);
    logic [7:0]  op;
    logic [22:0] d;
    logic [31:0] r;
    logic [63:0] v;
    int          ch;
    bit          memrd;
    exp_t        e;
    op = w[31:24];
    d = w[22:0];
    r = w;
    memrd = 0;
    ch = int'(d[3:0]);
    case (op)
      8'h01: m_rst = d[0];
      8'h02: m_tx = d[0];
      8'h03: m_rx = d[0];
      8'h04: m_ph = d[1:0];
      8'h05: m_rl = 0;
      8'h06, 8'h07: begin
        if (mem_full) begin
          if (op == 8'h06) begin
            m_addr = int'(d[14:0]);
            m_rl = 1;
          end else begin
            m_addr = (m_addr + 1) % 32768;
          end
          memrd = 1;
          r = memf(15'(m_addr));
        end else begin
          r = 32'hFFFF_FFFE;
        end
      end
      8'h08: r = {31'd0, mem_full};
      8'h09: begin
        for (int k = 0; k < N_CH; k++) begin
          snap_s[k] = live_s[k];
          snap_e[k] = live_e[k];
        end
        r = 32'd1;
      end
      8'h0A: begin
        if (ch >= N_CH) r = 32'hFFFF_FFFD;
        else begin
          v = d[4] ? snap_e[ch] : snap_s[ch];
          r = d[5] ? v[63:32] : v[31:0];
        end
      end
      8'h0B: begin
        r = {16'd0, m_ovf, 7'd0, 8'(N_CH)};
        m_ovf = 0;
      end
      default: r = {8'hEE, 16'd0, op};
    endcase
    e.due  = t_issue + 4 + extra + (memrd ? LAT : 0);
    e.data = r;
    e.ctrl = {m_rst, m_tx, m_rx, m_ph, m_rl, 15'(m_addr)};
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] w);
    @(negedge clock);
    cmd = w | EN;
    t_issue = cyc;
    @(negedge clock);
    cmd = w & ~EN;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: %0d responses outstanding", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic send(input logic [31:0] w);
    drive(w);
    model_push(w | EN, 0);
    wait_done();
  endtask

  initial begin
    logic [7:0]  op;
    logic [22:0] d;
    for (int k = 0; k < N_CH; k++) begin
      live_s[k] = '0;
      live_e[k] = '0;
    end
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_data", rsp, 32'd0);
    chk("reset_ctrl", 32'(dut_ctrl), 32'd0);
    chk("reset_run", 32'(o_run_log), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // EN_TX lands exactly 4 cycles after the strobe edge
    drive(mk(8'h02, 23'd1));
    model_push(mk(8'h02, 23'd1) | EN, 0);
    repeat (2) @(negedge clock);
    chk("enbtx_not_early", 32'(o_enbTx), 32'd0);
    wait_done();

    drive(mk(8'h05, 23'd0));
    run_at = t_issue + 4;
    model_push(mk(8'h05, 23'd0) | EN, 0);
    wait_done();
    run_at = -10;

    mem_full = 1'b1;
    send(mk(8'h06, 23'h7FFF));
    send(mk(8'h07, 23'd0));

    live_e[1] = 64'h0000_0012_3456_789A;
    send(mk(8'h09, 23'd0));
    live_e[1] = {$urandom, $urandom};
    live_s[0] = {$urandom, $urandom};
    send(mk(8'h0A, 23'h31));
    send(mk(8'h0A, 23'h11));

    mem_full = 1'b0;
    send(mk(8'h06, 23'h1234));
    send(mk(8'h0A, 23'h05));
    send(mk(8'h3C, 23'd0));
    send(mk(8'h00, 23'h55));

    // Events during a memory read: first is queued, second is dropped
    mem_full = 1'b1;
    drive(mk(8'h06, 23'h0100));
    model_push(mk(8'h06, 23'h0100) | EN, 0);
    drive(mk(8'h03, 23'd1));
    model_push(mk(8'h03, 23'd1) | EN, 4);
    drive(mk(8'h02, 23'd0));
    m_ovf = 1;
    wait_done();
    send(mk(8'h0B, 23'd0));
    send(mk(8'h0B, 23'd0));

    // Async reset in the middle of a memory wait
    drive(mk(8'h06, 23'h0ABC));
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midreset_data", rsp, 32'd0);
    chk("midreset_ctrl", 32'(dut_ctrl), 32'd0);
    chk("midreset_run", 32'(o_run_log), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("no_stale_mem", rsp, 32'd0);
    send(mk(8'h03, 23'd1));

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < N_CH; k++) begin
        live_s[k] = {$urandom, $urandom};
        live_e[k] = {$urandom, $urandom};
      end
      mem_full = 1'($urandom_range(0, 1));
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      d = 23'($urandom);
      if (op == 8'h0A && $urandom_range(0, 1) == 1) d[3:0] = 4'($urandom_range(0, N_CH - 1));
      send(mk(op, d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
